// File: rtl/cnn_ctrl_pkg.sv
// Shared CNN control definitions: layer state codes, unit phases and index widths.
// The state codes are also decoded by the BRAM enable controller, so keep them stable.
package cnn_ctrl_pkg;

  localparam int STATE_W = 4;
  localparam int LOOP_W  = 2;
  localparam int FILT_W  = 4;
  localparam int POOL_W  = 3;

  typedef enum logic [STATE_W-1:0] {
    RESET     = 4'd0,
    IDLE      = 4'd1,
    CONV1_1   = 4'd2,
    CONV1_2   = 4'd3,
    AVG_POOL1 = 4'd4,
    CONV2_1   = 4'd5,
    CONV2_2   = 4'd6,
    AVG_POOL2 = 4'd7,
    CONV3_1   = 4'd8,
    CONV3_2   = 4'd9,
    AVG_POOL3 = 4'd10,
    FC        = 4'd11,
    JUDGE     = 4'd12
  } layer_t;

  typedef enum logic [1:0] {
    SETUP = 2'd0,
    GO    = 2'd1,
    WAIT  = 2'd2
  } phase_t;

  function automatic layer_t next_layer(input layer_t s);
    layer_t n;
    case (s)
      CONV1_1:   n = CONV1_2;
      CONV1_2:   n = AVG_POOL1;
      AVG_POOL1: n = CONV2_1;
      CONV2_1:   n = CONV2_2;
      CONV2_2:   n = AVG_POOL2;
      AVG_POOL2: n = CONV3_1;
      CONV3_1:   n = CONV3_2;
      CONV3_2:   n = AVG_POOL3;
      AVG_POOL3: n = FC;
      FC:        n = JUDGE;
      default:   n = IDLE;
    endcase
    return n;
  endfunction

  function automatic logic is_conv(input layer_t s);
    return (s == CONV1_1) || (s == CONV1_2) || (s == CONV2_1) ||
           (s == CONV2_2) || (s == CONV3_1) || (s == CONV3_2);
  endfunction

  function automatic logic is_pool(input layer_t s);
    return (s == AVG_POOL1) || (s == AVG_POOL2) || (s == AVG_POOL3);
  endfunction

  function automatic logic is_work(input layer_t s);
    return (s >= CONV1_1) && (s <= JUDGE);
  endfunction

endpackage

// File: rtl/nest_cnt.sv
// Two-level wrapping counter: inner steps 0..inner_max, outer advances on each inner wrap.
// last flags the final unit so the caller can advance layers on the same step.
module nest_cnt #(
  parameter int IW = 4,
  parameter int OW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          step,
  input  logic          clr,
  input  logic [IW-1:0] inner_max,
  input  logic [OW-1:0] outer_max,
  output logic [IW-1:0] inner,
  output logic [OW-1:0] outer,
  output logic          last
);

  logic inner_wrap;
  logic outer_wrap;

  // >= rather than == so a stale count can never run past the active limit
  assign inner_wrap = (inner >= inner_max);
  assign outer_wrap = (outer >= outer_max);
  assign last       = inner_wrap && outer_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inner <= '0;
      outer <= '0;
    end else if (clr) begin
      inner <= '0;
      outer <= '0;
    end else if (step) begin
      if (inner_wrap) begin
        inner <= '0;
        outer <= outer_wrap ? '0 : outer + 1'b1;
      end else begin
        inner <= inner + 1'b1;
      end
    end
  end

endmodule

// File: rtl/layer_sequencer.sv
// Frame scheduler: walks CONV1_1 .. JUDGE, issuing one go per work unit and waiting for unit_done.
// Each unit runs SETUP -> GO -> WAIT so the BRAM enables settle one cycle before go.
module layer_sequencer
  import cnn_ctrl_pkg::*;
#(
  parameter int C1_FILT  = 6,
  parameter int C1_LOOP  = 2,
  parameter int C2_FILT  = 16,
  parameter int C2_LOOP  = 4,
  parameter int C3_FILT  = 16,
  parameter int C3_LOOP  = 4,
  parameter int P1_LOOP  = 3,
  parameter int P23_LOOP = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              unit_done,
  output logic [STATE_W-1:0] state,
  output logic [LOOP_W-1:0]  current_loop,
  output logic [FILT_W-1:0]  current_filter,
  output logic [POOL_W-1:0]  Pool_loop,
  output logic              go,
  output logic              busy,
  output logic              frame_done,
  output logic              err_spurious
);

  if (C1_FILT < 1 || C1_FILT > 16 || C1_LOOP < 1 || C1_LOOP > 4) begin : g_c1_range
    $error("layer_sequencer: CONV1 filter/loop count out of range");
  end
  if (C2_FILT < 1 || C2_FILT > 16 || C2_LOOP < 1 || C2_LOOP > 4) begin : g_c2_range
    $error("layer_sequencer: CONV2 filter/loop count out of range");
  end
  if (C3_FILT < 1 || C3_FILT > 16 || C3_LOOP < 1 || C3_LOOP > 4) begin : g_c3_range
    $error("layer_sequencer: CONV3 filter/loop count out of range");
  end
  if (P1_LOOP < 1 || P1_LOOP > 8 || P23_LOOP < 1 || P23_LOOP > 8) begin : g_pool_range
    $error("layer_sequencer: pool unit count out of range");
  end

  localparam logic [FILT_W-1:0] C1_FMAX  = FILT_W'(C1_FILT - 1);
  localparam logic [LOOP_W-1:0] C1_LMAX  = LOOP_W'(C1_LOOP - 1);
  localparam logic [FILT_W-1:0] C2_FMAX  = FILT_W'(C2_FILT - 1);
  localparam logic [LOOP_W-1:0] C2_LMAX  = LOOP_W'(C2_LOOP - 1);
  localparam logic [FILT_W-1:0] C3_FMAX  = FILT_W'(C3_FILT - 1);
  localparam logic [LOOP_W-1:0] C3_LMAX  = LOOP_W'(C3_LOOP - 1);
  localparam logic [FILT_W-1:0] P1_MAX   = FILT_W'(P1_LOOP - 1);
  localparam logic [FILT_W-1:0] P23_MAX  = FILT_W'(P23_LOOP - 1);

  layer_t state_reg;
  phase_t phase_reg;
  logic   go_reg;
  logic   busy_reg;
  logic   frame_done_reg;
  logic   err_reg;

  logic [FILT_W-1:0] inner_max;
  logic [LOOP_W-1:0] outer_max;
  logic [FILT_W-1:0] cnt_inner;
  logic [LOOP_W-1:0] cnt_outer;
  logic              cnt_last;
  logic              cnt_step;
  logic              cnt_clr;
  logic              in_wait;
  logic              spurious;
  logic              start_ok;

  assign in_wait  = is_work(state_reg) && (phase_reg == WAIT);
  // unit_done anywhere but WAIT (including the go cycle) is flagged and never sequenced
  assign spurious = unit_done && !in_wait;
  assign start_ok = start && !abort && (state_reg == IDLE);
  assign cnt_step = unit_done && in_wait && !abort;
  assign cnt_clr  = abort || (state_reg == IDLE);

  // Per-layer limits; pool, FC and JUDGE use only the inner level
  always_comb begin
    inner_max = '0;
    outer_max = '0;
    case (state_reg)
      CONV1_1, CONV1_2: begin
        inner_max = C1_FMAX;
        outer_max = C1_LMAX;
      end
      CONV2_1, CONV2_2: begin
        inner_max = C2_FMAX;
        outer_max = C2_LMAX;
      end
      CONV3_1, CONV3_2: begin
        inner_max = C3_FMAX;
        outer_max = C3_LMAX;
      end
      AVG_POOL1:            inner_max = P1_MAX;
      AVG_POOL2, AVG_POOL3: inner_max = P23_MAX;
      default: begin
        inner_max = '0;
        outer_max = '0;
      end
    endcase
  end

  nest_cnt #(
    .IW(FILT_W),
    .OW(LOOP_W)
  ) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .step      (cnt_step),
    .clr       (cnt_clr),
    .inner_max (inner_max),
    .outer_max (outer_max),
    .inner     (cnt_inner),
    .outer     (cnt_outer),
    .last      (cnt_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= RESET;
      phase_reg      <= SETUP;
      go_reg         <= 1'b0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      go_reg         <= 1'b0;
      frame_done_reg <= 1'b0;
      if (spurious) begin
        err_reg <= 1'b1;
      end else if (start_ok) begin
        err_reg <= 1'b0;
      end

      if (abort) begin
        state_reg <= IDLE;
        phase_reg <= SETUP;
        busy_reg  <= 1'b0;
      end else begin
        case (state_reg)
          RESET: begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
          IDLE: begin
            if (start) begin
              state_reg <= CONV1_1;
              phase_reg <= SETUP;
              busy_reg  <= 1'b1;
            end
          end
          default: begin
            if (!is_work(state_reg)) begin
              state_reg <= IDLE;
              phase_reg <= SETUP;
              busy_reg  <= 1'b0;
            end else begin
              case (phase_reg)
                SETUP: begin
                  phase_reg <= GO;
                  go_reg    <= 1'b1;
                end
                GO: phase_reg <= WAIT;
                WAIT: begin
                  if (unit_done) begin
                    phase_reg <= SETUP;
                    if (cnt_last) begin
                      state_reg <= next_layer(state_reg);
                      if (state_reg == JUDGE) begin
                        busy_reg       <= 1'b0;
                        frame_done_reg <= 1'b1;
                      end
                    end
                  end
                end
                default: phase_reg <= SETUP;
              endcase
            end
          end
        endcase
      end
    end
  end

  assign state          = state_reg;
  assign current_filter = is_conv(state_reg) ? cnt_inner : '0;
  assign current_loop   = is_conv(state_reg) ? cnt_outer : '0;
  assign Pool_loop      = is_pool(state_reg) ? cnt_inner[POOL_W-1:0] : '0;
  assign go             = go_reg;
  assign busy           = busy_reg;
  assign frame_done     = frame_done_reg;
  assign err_spurious   = err_reg;

endmodule
